// File: rtl/tron_pkg.sv
// Shared definitions for the Tron player logic: direction codes, mover FSM states
// and default arena size.
package tron_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PEND  = 2'd2,
    ST_CRASH = 2'd3
  } state_t;

  localparam int DEF_GRID_W = 160;
  localparam int DEF_GRID_H = 120;

endpackage

// File: rtl/tick_divider.sv
// Movement-tick generator: counts while run is high, freezes while hold is high,
// clears whenever run is low. Shared with the other player and the game timer.
module tick_divider #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!hold) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // A frozen counter parked on LAST must not keep re-firing.
  assign tick = run & ~hold & (count == LAST);

endmodule

// File: rtl/player_mover.sv
// Advances one player's grid position per movement tick and hands each step to the
// draw path. Define TRON_WRAP_AROUND_EN to wrap at the arena edges instead of crashing.
//
// Handshake: a step is taken only in a cycle where a tick is due (or pending) and
// draw_ready is high; move_valid pulses for one cycle with x/y already holding the
// new cell. A due step seen with draw_ready low parks in PEND until draw_ready rises.
module player_mover
  import tron_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int TICK_DIV = 2500000,
  parameter int START_X  = 80,
  parameter int START_Y  = 60
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           enable,
  input  logic [1:0]     direction,
  input  logic           draw_ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           move_valid,
  output logic           crashed,
  output logic [1:0]     state_dbg
);

`ifdef TRON_WRAP_AROUND_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  state_t         state, state_nxt;
  logic           tick, step, at_edge, hit, crashed_q;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .run    ((state == ST_RUN) || (state == ST_PEND)),
    .hold   (state == ST_PEND),
    .tick   (tick)
  );

  // Candidate next cell; the wrapped value is only ever committed in the wrap build.
  always_comb begin
    x_nxt   = x;
    y_nxt   = y;
    at_edge = 1'b0;
    case (direction)
      DIR_UP: begin
        at_edge = (y == '0);
        y_nxt   = at_edge ? Y_MAX : y - Y_W'(1);
      end
      DIR_RIGHT: begin
        at_edge = (x == X_MAX);
        x_nxt   = at_edge ? '0 : x + X_W'(1);
      end
      DIR_DOWN: begin
        at_edge = (y == Y_MAX);
        y_nxt   = at_edge ? '0 : y + Y_W'(1);
      end
      default: begin
        at_edge = (x == '0);
        x_nxt   = at_edge ? X_MAX : x - X_W'(1);
      end
    endcase
  end

  assign hit = at_edge & ~WRAP;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Loss of enable outranks both a due tick and a pending step.
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_RUN;
      ST_RUN: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (draw_ready) step = 1'b1;
          else            state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (draw_ready) begin
          step      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_CRASH;
    endcase
    if (step && hit) state_nxt = ST_CRASH;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      x          <= X_W'(START_X);
      y          <= Y_W'(START_Y);
      move_valid <= 1'b0;
      crashed_q  <= 1'b0;
    end else begin
      move_valid <= 1'b0;
      if (step) begin
        if (hit) begin
          crashed_q <= 1'b1;
        end else begin
          x          <= x_nxt;
          y          <= y_nxt;
          move_valid <= 1'b1;
        end
      end
    end
  end

  assign crashed   = crashed_q & ~WRAP;
  assign state_dbg = state;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover with a fast tick; expectations switch on
// TRON_WRAP_AROUND_EN for the arena-edge sequence.
module tb_player_mover;
  import tron_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable, draw_ready;
  logic [1:0] dir;
  logic [7:0] x;
  logic [6:0] y;
  logic       mv, cr;
  logic [1:0] st;

  logic       e_enable, e_draw_ready;
  logic [1:0] e_dir;
  logic [7:0] e_x;
  logic [6:0] e_y;
  logic       e_mv, e_cr;
  logic [1:0] e_st;

  int checks = 0;
  int errors = 0;
  int mv_cnt;

  always #5 clk = ~clk;

  player_mover #(.TICK_DIV(4)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .direction(dir),
    .draw_ready(draw_ready), .x(x), .y(y), .move_valid(mv), .crashed(cr),
    .state_dbg(st)
  );

  player_mover #(.TICK_DIV(4), .START_X(1)) dut_edge (
    .CLOCK_50(clk), .resetn(resetn), .enable(e_enable), .direction(e_dir),
    .draw_ready(e_draw_ready), .x(e_x), .y(e_y), .move_valid(e_mv), .crashed(e_cr),
    .state_dbg(e_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cycles_count_mv(input int n);
    mv_cnt = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mv) mv_cnt++;
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; draw_ready = 1'b1; dir = DIR_RIGHT;
    e_enable = 1'b0; e_draw_ready = 1'b1; e_dir = DIR_LEFT;
    cycles(2);
    check("rst_x", x, 80);
    check("rst_y", y, 60);
    check("rst_mv", mv, 0);
    check("rst_cr", cr, 0);
    check("rst_st", st, ST_IDLE);
    check("rst_edge_x", e_x, 1);

    // Move right: first step lands on the fifth edge, then every fourth.
    resetn = 1'b1;
    cycles(1);
    enable = 1'b1;
    cycles_count_mv(4);
    check("first_wait_mv", mv_cnt, 0);
    check("first_wait_x", x, 80);
    cycles(1);
    check("step1_mv", mv, 1);
    check("step1_x", x, 81);
    check("step1_y", y, 60);
    check("step1_st", st, ST_RUN);
    cycles_count_mv(3);
    check("gap_mv", mv_cnt, 0);
    cycles(1);
    check("step2_mv", mv, 1);
    check("step2_x", x, 82);
    check("step2_cr", cr, 0);

    // Tick with draw_ready low parks the step; one step once it rises.
    dir = DIR_UP; draw_ready = 1'b0;
    cycles_count_mv(4);
    check("pend_st", st, ST_PEND);
    cycles_count_mv(10);
    check("pend_hold_mv", mv_cnt, 0);
    check("pend_hold_y", y, 60);
    draw_ready = 1'b1;
    cycles(1);
    check("pend_step_mv", mv, 1);
    check("pend_step_y", y, 59);
    check("pend_step_x", x, 82);
    check("pend_step_st", st, ST_RUN);
    cycles_count_mv(3);
    check("post_pend_gap", mv_cnt, 0);
    cycles(1);
    check("post_pend_mv", mv, 1);
    check("post_pend_y", y, 58);

    // Drop enable at count 2; re-enable restarts a full count.
    cycles(2);
    enable = 1'b0;
    cycles(1);
    check("pause_st", st, ST_IDLE);
    cycles_count_mv(3);
    check("pause_mv", mv_cnt, 0);
    enable = 1'b1;
    cycles_count_mv(4);
    check("reen_wait_mv", mv_cnt, 0);
    cycles(1);
    check("reen_mv", mv, 1);
    check("reen_y", y, 57);

    // Enable falls in the tick cycle: no step.
    cycles(3);
    enable = 1'b0;
    cycles(1);
    check("tie_mv", mv, 0);
    check("tie_y", y, 57);
    check("tie_st", st, ST_IDLE);

    // Arena edge on the second instance, starting at x=1 heading left.
    e_enable = 1'b1;
    cycles(5);
    check("edge1_mv", e_mv, 1);
    check("edge1_x", e_x, 0);
    cycles(3);
    cycles(1);
`ifdef TRON_WRAP_AROUND_EN
    check("wrapl_x", e_x, 159);
    check("wrapl_mv", e_mv, 1);
    check("wrapl_cr", e_cr, 0);
`else
    check("crash_cr", e_cr, 1);
    check("crash_x", e_x, 0);
    check("crash_mv", e_mv, 0);
    check("crash_st", e_st, ST_CRASH);
`endif
    e_dir = DIR_RIGHT;
    mv_cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (e_mv) mv_cnt++;
    end
`ifdef TRON_WRAP_AROUND_EN
    check("wrapr_x", e_x, 0);
    check("wrapr_mvs", mv_cnt, 1);
    check("wrapr_cr", e_cr, 0);
    check("wrapr_st", e_st, ST_RUN);
`else
    check("crash_hold_x", e_x, 0);
    check("crash_hold_mvs", mv_cnt, 0);
    check("crash_hold_cr", e_cr, 1);
    check("crash_hold_st", e_st, ST_CRASH);
`endif

    // Asynchronous reset while a step is pending.
    draw_ready = 1'b0; enable = 1'b1;
    cycles(5);
    check("areset_pre_st", st, ST_PEND);
    #3;
    resetn = 1'b0;
    #1;
    check("areset_x", x, 80);
    check("areset_y", y, 60);
    check("areset_mv", mv, 0);
    check("areset_cr", cr, 0);
    check("areset_st", st, ST_IDLE);
    check("areset_edge_x", e_x, 1);
    check("areset_edge_cr", e_cr, 0);
    #2;
    resetn = 1'b1;
    draw_ready = 1'b1;
    cycles_count_mv(4);
    check("areset_no_step", mv_cnt, 0);
    check("areset_after_x", x, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
